// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// the default reset vector and the address that halts the CPU.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR            = 32'h00000000;

endpackage

// File: rtl/pc_sequencer_target_holder.sv
// Holds the branch/jump target captured when a control instruction completes,
// so it can be applied after the delay-slot instruction.
module target_addr_holder (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (reset)
            r_q <= 32'h0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_sequencer.sv
// Two-state fetch/execute PC sequencer with a single branch delay slot and a
// halt state entered when the next PC would be address zero.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        mem_access,
    input  logic        is_ctrl,
    input  logic [31:0] tgt_addr_0,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_read,
    output logic        exec_en,
    output logic [1:0]  state,
    output logic        active
);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_delay_pending, w_dp_nxt;
    logic [31:0] w_held_tgt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_complete;

    assign w_pc_plus4 = r_pc + 32'd4;
    // An EXEC cycle completes unless a memory access is still being stalled.
    assign w_complete = (r_state == EXEC) && (!mem_access || !waitrequest);
    assign w_next_pc  = r_delay_pending ? w_held_tgt : w_pc_plus4;

    target_addr_holder u_tgt_holder (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_complete & is_ctrl),
        .i_d   (tgt_addr_0),
        .o_q   (w_held_tgt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= FETCH;
            r_pc            <= RESET_VECTOR;
            r_delay_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_delay_pending <= w_dp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_dp_nxt    = r_delay_pending;
        instr_read  = 1'b0;
        exec_en     = 1'b0;
        active      = 1'b1;
        case (r_state)
            FETCH: begin
                instr_read = 1'b1;
                if (!waitrequest)
                    w_state_nxt = EXEC;
            end
            EXEC: begin
                if (w_complete) begin
                    exec_en  = 1'b1;
                    w_dp_nxt = is_ctrl;
                    if (w_next_pc == HALT_ADDR) begin
                        w_state_nxt = HALTED;
                        w_pc_nxt    = HALT_ADDR;
                    end else begin
                        w_state_nxt = FETCH;
                        w_pc_nxt    = w_next_pc;
                    end
                end
            end
            HALTED: begin
                active = 1'b0;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign state    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test of pc_sequencer: straight-line run, branch delay slot, stalls,
// back-to-back control, reset mid-stall, PC wrap and halt.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        waitrequest;
    logic        mem_access;
    logic        is_ctrl;
    logic [31:0] tgt_addr_0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_read;
    logic        exec_en;
    logic [1:0]  state;
    logic        active;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] RV = 32'hBFC00000;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .waitrequest (waitrequest),
        .mem_access  (mem_access),
        .is_ctrl     (is_ctrl),
        .tgt_addr_0  (tgt_addr_0),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_read  (instr_read),
        .exec_en     (exec_en),
        .state       (state),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; waitrequest = 1'b1; mem_access = 1'b1;
        is_ctrl = 1'b1; tgt_addr_0 = 32'hDEADBEEF;
        cyc();
        reset = 1'b0; waitrequest = 1'b0; mem_access = 1'b0;
        is_ctrl = 1'b0; tgt_addr_0 = 32'h0;
    endtask

    // From FETCH with no stalls: fetch, then execute one instruction.
    task automatic run_instr(input string tag, input logic ctrl, input logic [31:0] tgt);
        cyc();
        chk({tag, "_st_exec"}, {30'd0, state}, 32'd1);
        is_ctrl = ctrl; tgt_addr_0 = tgt;
        #1;
        chk({tag, "_exec_en"}, {31'd0, exec_en}, 32'd1);
        cyc();
        is_ctrl = 1'b0; tgt_addr_0 = 32'h0;
    endtask

    initial begin
        reset = 1'b0; waitrequest = 1'b0; mem_access = 1'b0;
        is_ctrl = 1'b0; tgt_addr_0 = 32'h0;

        // Reset and straight-line run
        do_reset();
        chk("rst_pc", pc, RV);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_ird", {31'd0, instr_read}, 32'd1);
        chk("rst_exen", {31'd0, exec_en}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_pcp4", pc_plus4, 32'hBFC00004);
        run_instr("s0", 1'b0, 32'h0);
        chk("s0_pc", pc, 32'hBFC00004);
        chk("s0_st", {30'd0, state}, 32'd0);
        run_instr("s1", 1'b0, 32'h0);
        chk("s1_pc", pc, 32'hBFC00008);
        run_instr("s2", 1'b0, 32'h0);
        chk("s2_pc", pc, 32'hBFC0000C);

        // Branch with delay slot
        do_reset();
        run_instr("b0", 1'b1, 32'hBFC00100);
        chk("b0_pc", pc, 32'hBFC00004);
        run_instr("b1", 1'b0, 32'h0);
        chk("b1_pc", pc, 32'hBFC00100);
        run_instr("b2", 1'b0, 32'h0);
        chk("b2_pc", pc, 32'hBFC00104);

        // Fetch stall 3 cycles, then data stall 2 cycles
        do_reset();
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fst_exen", {31'd0, exec_en}, 32'd0);
            cyc();
            chk("fst_state", {30'd0, state}, 32'd0);
            chk("fst_ird", {31'd0, instr_read}, 32'd1);
        end
        waitrequest = 1'b0;
        cyc();
        chk("fst_to_exec", {30'd0, state}, 32'd1);
        mem_access = 1'b1; waitrequest = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("dst_exen0", {31'd0, exec_en}, 32'd0);
            cyc();
            chk("dst_state", {30'd0, state}, 32'd1);
            chk("dst_pc", pc, RV);
        end
        waitrequest = 1'b0;
        #1;
        chk("dst_exen1", {31'd0, exec_en}, 32'd1);
        cyc();
        mem_access = 1'b0;
        chk("dst_done_st", {30'd0, state}, 32'd0);
        chk("dst_done_pc", pc, 32'hBFC00004);
        #1;
        chk("dst_fetch_exen", {31'd0, exec_en}, 32'd0);

        // Control instruction in a delay slot
        do_reset();
        run_instr("bb0", 1'b1, 32'hBFC00100);
        chk("bb0_pc", pc, 32'hBFC00004);
        run_instr("bb1", 1'b1, 32'hBFC00200);
        chk("bb1_pc", pc, 32'hBFC00100);
        run_instr("bb2", 1'b0, 32'h0);
        chk("bb2_pc", pc, 32'hBFC00200);
        run_instr("bb3", 1'b0, 32'h0);
        chk("bb3_pc", pc, 32'hBFC00204);

        // Reset during an EXEC stall with a delay slot pending
        do_reset();
        run_instr("rm0", 1'b1, 32'hBFC00300);
        cyc();
        mem_access = 1'b1; waitrequest = 1'b1;
        cyc();
        chk("rm_stall_st", {30'd0, state}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0; mem_access = 1'b0; waitrequest = 1'b0;
        chk("rm_pc", pc, RV);
        chk("rm_state", {30'd0, state}, 32'd0);
        run_instr("rm1", 1'b0, 32'h0);
        chk("rm_no_pending", pc, 32'hBFC00004);

        // PC wrap: executing at FFFFFFFC gives next_pc 0 and halts
        do_reset();
        run_instr("w0", 1'b1, 32'hFFFFFFFC);
        run_instr("w1", 1'b0, 32'h0);
        chk("w_pc", pc, 32'hFFFFFFFC);
        chk("w_pcp4", pc_plus4, 32'h0);
        run_instr("w2", 1'b0, 32'h0);
        chk("w_halt_st", {30'd0, state}, 32'd2);

        // Halt via JR to address zero after its delay slot
        do_reset();
        run_instr("h0", 1'b1, 32'h0);
        chk("h0_pc", pc, 32'hBFC00004);
        run_instr("h1", 1'b0, 32'h0);
        chk("h_state", {30'd0, state}, 32'd2);
        chk("h_pc", pc, 32'h0);
        chk("h_active", {31'd0, active}, 32'd0);
        chk("h_ird", {31'd0, instr_read}, 32'd0);
        is_ctrl = 1'b1; tgt_addr_0 = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("h_exen", {31'd0, exec_en}, 32'd0);
            cyc();
            chk("h_stay", {30'd0, state}, 32'd2);
            chk("h_pc_stay", pc, 32'h0);
        end
        is_ctrl = 1'b0;
        do_reset();
        chk("h_rst_st", {30'd0, state}, 32'd0);
        chk("h_rst_pc", pc, RV);
        chk("h_rst_active", {31'd0, active}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
